// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per cycle through an external 4-bit adder stage,
// with a registered inter-nibble carry and valid/ready handshakes on both host sides.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_sum,
  output logic [3:0]       o_add_a,
  output logic [3:0]       o_add_b,
  output logic             o_add_c,
  input  logic [4:0]       i_add_s
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [IW-1:0]    r_idx;

  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  // Adder stage is fed only while running; otherwise it sees zeros.
  always_comb begin
    o_ready = (r_state == S_IDLE) && !i_rst;
    o_add_a = 4'h0;
    o_add_b = 4'h0;
    o_add_c = 1'b0;
    if (r_state == S_RUN) begin
      o_add_a = r_a[3:0];
      o_add_b = r_b[3:0];
      o_add_c = r_carry;
    end
  end

  // Accumulator with the current adder nibble merged into slot r_idx.
  always_comb begin
    w_acc_next = r_acc;
    for (int unsigned n = 0; n < NIBBLES; n++) begin
      if (r_idx == IW'(n)) begin
        w_acc_next[n*4 +: 4] = i_add_s[3:0];
      end
    end
    w_last = (r_idx == IW'(NIBBLES - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      o_valid <= 1'b0;
      o_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_c;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= i_add_s[4];
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            o_sum   <= {i_add_s[4], w_acc_next};
            o_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // o_sum is left untouched so it stays readable after the handshake.
          if (i_ready) begin
            o_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: 16-bit and 4-bit instances, each with a
// behavioural 4-bit adder stage, plus a scoreboard on the 16-bit result handshake.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, ready, c;
  logic [15:0] a, b;
  logic        o_ready, o_valid, o_add_c;
  logic [16:0] o_sum;
  logic [3:0]  o_add_a, o_add_b;
  logic [4:0]  add_s;

  logic        v4, r4, c4;
  logic [3:0]  a4, b4;
  logic        o_ready4, o_valid4, o_add_c4;
  logic [4:0]  o_sum4;
  logic [3:0]  o_add_a4, o_add_b4;
  logic [4:0]  add_s4;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int cyc = 0;
  logic [16:0] sb_q[$];
  logic [16:0] sb_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 4-bit adder stages
  assign add_s  = 5'(o_add_a)  + 5'(o_add_b)  + 5'(o_add_c);
  assign add_s4 = 5'(o_add_a4) + 5'(o_add_b4) + 5'(o_add_c4);

  nibble_serial_adder #(.WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
    .i_a(a), .i_b(b), .i_c(c), .o_valid(o_valid), .i_ready(ready),
    .o_sum(o_sum), .o_add_a(o_add_a), .o_add_b(o_add_b), .o_add_c(o_add_c),
    .i_add_s(add_s)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(o_ready4),
    .i_a(a4), .i_b(b4), .i_c(c4), .o_valid(o_valid4), .i_ready(r4),
    .o_sum(o_sum4), .o_add_a(o_add_a4), .o_add_b(o_add_b4), .o_add_c(o_add_c4),
    .i_add_s(add_s4)
  );

  // Scoreboard: push on accept, pop and compare on result handshake; reset flushes.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (valid && o_ready) sb_q.push_back(17'(a) + 17'(b) + 17'(c));
      if (o_valid && ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: result %h with no pending op", o_sum);
        end else begin
          sb_e = sb_q.pop_front();
          if (o_sum !== sb_e) begin
            errors++;
            $display("FAIL sb_sum: got %h expected %h", o_sum, sb_e);
          end
        end
        done_cnt++;
      end
    end
  end

  // Present one operand set at posedge+1 while idle; returns one step after the accept edge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    a = ta; b = tb; c = tc; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Count edges until o_valid is seen at a falling edge, bounded by budget.
  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!o_valid && lat < budget);
  endtask

  task automatic pulse_ready;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; ready = 1'b0; a = '0; b = '0; c = 1'b0;
    v4 = 1'b0; r4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
    checks++; if (o_sum !== 17'h0) begin errors++; $display("FAIL rst_sum: got %h expected 0", o_sum); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", o_ready); end
    checks++; if ({o_add_a, o_add_b, o_add_c} !== 9'h0) begin
      errors++; $display("FAIL idle_add: got %h expected 0", {o_add_a, o_add_b, o_add_c});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    int lat;
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_valid(10, lat);
    checks++; if (lat !== 4 || !o_valid) begin errors++; $display("FAIL t1_latency: got %0d expected 4", lat); end
    checks++; if (o_sum !== 17'h10000) begin errors++; $display("FAIL t1_sum: got %h expected 10000", o_sum); end
    @(posedge clk); #1;
    pulse_ready();
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_drop: got %b expected 0", o_valid); end
    checks++; if (o_sum !== 17'h10000) begin errors++; $display("FAIL t1_sum_held: got %h expected 10000", o_sum); end
    @(posedge clk); #1;
  endtask

  task automatic test_nibble_stream;
    logic [15:0] ta, tb;
    logic        cy;
    logic [4:0]  s;
    int          lat;
    ta = 16'h1234; tb = 16'h4321; cy = 1'b1;
    start_op(ta, tb, cy);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (o_add_a !== ta[3:0] || o_add_b !== tb[3:0] || o_add_c !== cy) begin
        errors++;
        $display("FAIL t2_nibble%0d: got a=%h b=%h c=%b expected a=%h b=%h c=%b",
                 k, o_add_a, o_add_b, o_add_c, ta[3:0], tb[3:0], cy);
      end
      s = 5'(ta[3:0]) + 5'(tb[3:0]) + 5'(cy);
      cy = s[4]; ta = ta >> 4; tb = tb >> 4;
      @(posedge clk);
    end
    wait_valid(4, lat);
    checks++; if (o_sum !== 17'h05556) begin errors++; $display("FAIL t2_sum: got %h expected 05556", o_sum); end
    @(posedge clk); #1;
    pulse_ready();
  endtask

  task automatic test_backpressure;
    int lat;
    start_op(16'hBEEF, 16'h1111, 1'b0);
    wait_valid(10, lat);
    @(posedge clk); #1;
    a = 16'h7000; b = 16'h9000; c = 1'b1; valid = 1'b1; ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_sum !== 17'h0D000 || o_ready !== 1'b0 || o_valid !== 1'b1) begin
        errors++;
        $display("FAIL t3_hold%0d: got sum=%h rdy=%b vld=%b expected sum=0d000 rdy=0 vld=1",
                 k, o_sum, o_ready, o_valid);
      end
      @(posedge clk); #1;
    end
    ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL t3_idle: got rdy=%b vld=%b expected rdy=1 vld=0", o_ready, o_valid);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL t3_accept: got rdy=%b expected 0", o_ready); end
    wait_valid(10, lat);
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic test_abort;
    int  lat;
    bit  saw;
    start_op(16'hAAAA, 16'h5555, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL t4_rst_ready: got %b expected 0", o_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL t4_idle: got rdy=%b vld=%b expected rdy=1 vld=0", o_ready, o_valid);
    end
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (o_valid) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL t4_no_valid: got %b expected 0", saw); end
    @(posedge clk); #1;
    start_op(16'h00FF, 16'h0F01, 1'b0);
    wait_valid(10, lat);
    checks++; if (lat !== 4 || o_sum !== 17'h01000) begin
      errors++; $display("FAIL t4_sum: got %h lat %0d expected 01000 lat 4", o_sum, lat);
    end
    @(posedge clk); #1;
    pulse_ready();
  endtask

  task automatic test_width4;
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1; v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    @(negedge clk);
    checks++; if (o_valid4 !== 1'b0 || o_add_a4 !== 4'hF || o_add_c4 !== 1'b1) begin
      errors++; $display("FAIL t5_run: got vld=%b a=%h c=%b expected vld=0 a=f c=1", o_valid4, o_add_a4, o_add_c4);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (o_valid4 !== 1'b1 || o_sum4 !== 5'h1F) begin
      errors++; $display("FAIL t5_sum: got vld=%b sum=%h expected vld=1 sum=1f", o_valid4, o_sum4);
    end
    r4 = 1'b1;
    @(posedge clk); #1;
    r4 = 1'b0;
    @(negedge clk);
    checks++; if (o_valid4 !== 1'b0 || o_ready4 !== 1'b1) begin
      errors++; $display("FAIL t5_idle: got vld=%b rdy=%b expected vld=0 rdy=1", o_valid4, o_ready4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int prev, t;
    prev = 0;
    a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
    valid = 1'b1; ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!o_ready && t < 20);
      if (k > 0) begin
        checks++;
        if (cyc - prev !== 6) begin errors++; $display("FAIL t6_throughput%0d: got %0d expected 6", k, cyc - prev); end
      end
      prev = cyc;
      @(posedge clk); #1;
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
    end
    valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 ready = 1'b0;
  endtask

  task automatic test_random;
    int n, base, t, t2;
    n = 1000;
    base = done_cnt;
    t2 = 0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
          valid = 1'b1;
          t = 0;
          do begin @(negedge clk); t++; end while (!o_ready && t < 100);
          @(posedge clk); #1;
          valid = 1'b0;
        end
      end
      begin
        while ((done_cnt - base) < n && t2 < 40000) begin
          @(posedge clk); #1;
          ready = ($urandom_range(0, 3) != 0);
          t2++;
        end
        ready = 1'b0;
      end
    join
    checks++;
    if (done_cnt - base !== n) begin errors++; $display("FAIL t6_count: got %0d expected %0d", done_cnt - base, n); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_nibble_stream();
    test_backpressure();
    test_abort();
    test_width4();
    test_back_to_back();
    test_random();
    repeat (4) @(posedge clk);
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
